// File: rtl/wb_stage_cp0.sv
// Writeback stage with integrated CP0: commits GPR writes, MFC0/MTC0, exceptions, ERET,
// Count/Compare timer and interrupts. Never stalls; flush/redirect are combinational from WB.
module wb_stage_cp0 #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_ENTRY  = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  ws_allowin,
  input  logic                  ms_to_ws_valid,
  input  logic [31:0]           ms_pc,
  input  logic                  ms_gr_we,
  input  logic [4:0]            ms_dest,
  input  logic [31:0]           ms_result,
  input  logic                  ms_ex,
  input  logic [4:0]            ms_excode,
  input  logic                  ms_bd,
  input  logic [31:0]           ms_badvaddr,
  input  logic                  ms_eret,
  input  logic                  ms_mtc0,
  input  logic                  ms_mfc0,
  input  logic [7:0]            ms_cp0_addr,
  input  logic [NUM_HW_INT-1:0] ext_int,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic [4:0]            ws_dest,
  output logic [31:0]           ws_fwd_data,
  output logic                  ws_flush,
  output logic [31:0]           ws_flush_pc,
  output logic                  int_pending,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
);

  localparam logic [7:0] A_BADVADDR = 8'h40;
  localparam logic [7:0] A_COUNT    = 8'h48;
  localparam logic [7:0] A_COMPARE  = 8'h58;
  localparam logic [7:0] A_STATUS   = 8'h60;
  localparam logic [7:0] A_CAUSE    = 8'h68;
  localparam logic [7:0] A_EPC      = 8'h70;

  logic        ws_valid_q, ws_gr_we_q, ws_ex_q, ws_bd_q, ws_eret_q, ws_mtc0_q, ws_mfc0_q;
  logic [31:0] ws_pc_q, ws_result_q, ws_badvaddr_q;
  logic [4:0]  ws_dest_q, ws_excode_q;
  logic [7:0]  ws_cp0_addr_q;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic        bd_q, bd_d, ti_q, ti_d, eq_q, eq_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d, div_q, div_d;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic [NUM_HW_INT-1:0] hw_int_q;

  logic        commit, exc, eret, mtc0_we;
  logic [5:0]  hw_ip;
  logic [7:0]  cause_ip;
  logic [31:0] cp0_rdata;

  assign commit  = ws_valid_q;
  assign exc     = commit & ws_ex_q;
  assign eret    = commit & ~ws_ex_q & ws_eret_q;
  assign mtc0_we = commit & ~ws_ex_q & ws_mtc0_q;

  always_comb begin
    hw_ip = '0;
    for (int i = 0; i < NUM_HW_INT; i++) hw_ip[i] = hw_int_q[i];
  end
  // The timer shares the top IP line with the highest external interrupt.
  assign cause_ip = {hw_ip[5] | ti_q, hw_ip[4:0], ip_sw_q};

  always_comb begin
    cp0_rdata = '0;
    case (ws_cp0_addr_q)
      A_BADVADDR: cp0_rdata = badvaddr_q;
      A_COUNT:    cp0_rdata = count_q;
      A_COMPARE:  cp0_rdata = compare_q;
      A_STATUS:   cp0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
      A_CAUSE:    cp0_rdata = {bd_q, ti_q, 14'b0, cause_ip, 1'b0, exccode_q, 2'b0};
      A_EPC:      cp0_rdata = epc_q;
      default:    cp0_rdata = '0;
    endcase
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    eq_d       = (count_q == compare_q);
    ti_d       = ti_q | (eq_d & ~eq_q);
    if (div_q == 5'(COUNT_DIV - 1)) begin
      count_d = count_q + 32'd1;
      div_d   = '0;
    end else begin
      count_d = count_q;
      div_d   = div_q + 5'd1;
    end
    if (exc) begin
      exl_d     = 1'b1;
      exccode_d = ws_excode_q;
      if (!exl_q) begin
        epc_d = ws_bd_q ? ws_pc_q - 32'd4 : ws_pc_q;
        bd_d  = ws_bd_q;
      end
      if (ws_excode_q == 5'd4 || ws_excode_q == 5'd5) badvaddr_d = ws_badvaddr_q;
    end else begin
      if (eret) exl_d = 1'b0;
      if (mtc0_we) begin
        case (ws_cp0_addr_q)
          A_COUNT: begin
            count_d = ws_result_q;
            div_d   = '0;
          end
          A_COMPARE: begin
            compare_d = ws_result_q;
            ti_d      = 1'b0;
          end
          A_STATUS: begin
            im_d  = ws_result_q[15:8];
            exl_d = ws_result_q[1];
            ie_d  = ws_result_q[0];
          end
          A_CAUSE: ip_sw_d = ws_result_q[9:8];
          A_EPC:   epc_d   = ws_result_q;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q    <= 1'b0;
      ws_pc_q       <= '0;
      ws_gr_we_q    <= 1'b0;
      ws_dest_q     <= '0;
      ws_result_q   <= '0;
      ws_ex_q       <= 1'b0;
      ws_excode_q   <= '0;
      ws_bd_q       <= 1'b0;
      ws_badvaddr_q <= '0;
      ws_eret_q     <= 1'b0;
      ws_mtc0_q     <= 1'b0;
      ws_mfc0_q     <= 1'b0;
      ws_cp0_addr_q <= '0;
      im_q          <= '0;
      exl_q         <= 1'b0;
      ie_q          <= 1'b0;
      bd_q          <= 1'b0;
      ti_q          <= 1'b0;
      eq_q          <= 1'b1;  // Count == Compare out of reset is not a new match
      ip_sw_q       <= '0;
      exccode_q     <= '0;
      div_q         <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      count_q       <= '0;
      compare_q     <= '0;
      hw_int_q      <= '0;
    end else begin
      ws_valid_q <= ms_to_ws_valid & ~ws_flush;
      if (ms_to_ws_valid) begin
        ws_pc_q       <= ms_pc;
        ws_gr_we_q    <= ms_gr_we;
        ws_dest_q     <= ms_dest;
        ws_result_q   <= ms_result;
        ws_ex_q       <= ms_ex;
        ws_excode_q   <= ms_excode;
        ws_bd_q       <= ms_bd;
        ws_badvaddr_q <= ms_badvaddr;
        ws_eret_q     <= ms_eret;
        ws_mtc0_q     <= ms_mtc0;
        ws_mfc0_q     <= ms_mfc0;
        ws_cp0_addr_q <= ms_cp0_addr;
      end
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      eq_q       <= eq_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      div_q      <= div_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      hw_int_q   <= ext_int;
    end
  end

  assign ws_allowin        = 1'b1;
  assign rf_we             = commit & ws_gr_we_q & ~ws_ex_q;
  assign rf_waddr          = ws_dest_q;
  assign rf_wdata          = ws_mfc0_q ? cp0_rdata : ws_result_q;
  assign ws_dest           = (ws_valid_q & ws_gr_we_q) ? ws_dest_q : 5'd0;
  assign ws_fwd_data       = rf_wdata;
  assign ws_flush          = exc | eret;
  // Only ERET redirects to EPC; idle and exceptions both point at the vector.
  assign ws_flush_pc       = eret ? epc_q : EXC_ENTRY;
  assign int_pending       = ie_q & ~exl_q & |(cause_ip & im_q);
  assign debug_wb_pc       = ws_pc_q;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = ws_dest_q;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage_cp0.sv
// Directed bench for wb_stage_cp0: commits, CP0 access, exceptions, ERET, timer and interrupts.
module tb_wb_stage_cp0;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_to_ws_valid, ms_gr_we, ms_ex, ms_bd, ms_eret, ms_mtc0, ms_mfc0;
  logic [31:0] ms_pc, ms_result, ms_badvaddr;
  logic [4:0]  ms_dest, ms_excode;
  logic [7:0]  ms_cp0_addr;
  logic [5:0]  ext_int;
  logic        rf_we, ws_flush, int_pending;
  logic [4:0]  rf_waddr, ws_dest, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, ws_fwd_data, ws_flush_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;

  int errors = 0;
  int checks = 0;
  int n_hit;

  localparam logic [7:0] A_BADVADDR = 8'h40, A_COUNT = 8'h48, A_COMPARE = 8'h58;
  localparam logic [7:0] A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;

  wb_stage_cp0 #(.NUM_HW_INT(6), .COUNT_DIV(2), .EXC_ENTRY(32'hBFC00380)) dut (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_result(ms_result), .ms_ex(ms_ex), .ms_excode(ms_excode), .ms_bd(ms_bd),
    .ms_badvaddr(ms_badvaddr), .ms_eret(ms_eret), .ms_mtc0(ms_mtc0), .ms_mfc0(ms_mfc0),
    .ms_cp0_addr(ms_cp0_addr), .ext_int(ext_int),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_dest(ws_dest),
    .ws_fwd_data(ws_fwd_data), .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc),
    .int_pending(int_pending), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ms_to_ws_valid = 1'b0; ms_pc = '0; ms_gr_we = 1'b0; ms_dest = '0; ms_result = '0;
    ms_ex = 1'b0; ms_excode = '0; ms_bd = 1'b0; ms_badvaddr = '0; ms_eret = 1'b0;
    ms_mtc0 = 1'b0; ms_mfc0 = 1'b0; ms_cp0_addr = '0;
  endtask

  task automatic alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
    clr(); ms_to_ws_valid = 1'b1; ms_pc = pc; ms_gr_we = 1'b1; ms_dest = d; ms_result = r;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] v);
    clr(); ms_to_ws_valid = 1'b1; ms_pc = 32'hBFC00040; ms_mtc0 = 1'b1; ms_cp0_addr = a;
    ms_result = v;
  endtask

  task automatic eret_i();
    clr(); ms_to_ws_valid = 1'b1; ms_pc = 32'hBFC00050; ms_eret = 1'b1;
  endtask

  task automatic exc_i(input logic [31:0] pc, input logic [4:0] code, input logic bd,
                       input logic [31:0] bva);
    clr(); ms_to_ws_valid = 1'b1; ms_pc = pc; ms_ex = 1'b1; ms_excode = code; ms_bd = bd;
    ms_badvaddr = bva;
  endtask

  // Commit an MFC0 into r2 and compare the written-back value.
  task automatic rd_cp0(input string tag, input logic [7:0] a, input logic [31:0] exp);
    clr(); ms_to_ws_valid = 1'b1; ms_pc = 32'hBFC00060; ms_mfc0 = 1'b1; ms_gr_we = 1'b1;
    ms_dest = 5'd2; ms_cp0_addr = a;
    step();
    chk(tag, rf_wdata, exp);
  endtask

  initial begin
    resetn = 1'b0;
    ext_int = '0;
    clr();
    #12;
    chk("rst_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_flush", 32'(ws_flush), 32'd0);
    chk("rst_flush_pc", ws_flush_pc, 32'hBFC00380);
    chk("rst_int_pending", 32'(int_pending), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // ADDU commit
    alu(32'hBFC00000, 5'd5, 32'h1234);
    step();
    chk("alu_rf_we", 32'(rf_we), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", rf_wdata, 32'h1234);
    chk("alu_wen", 32'(debug_wb_rf_wen), 32'hF);
    chk("alu_ws_dest", 32'(ws_dest), 32'd5);
    chk("alu_dbg_pc", debug_wb_pc, 32'hBFC00000);
    rd_cp0("status_reset", A_STATUS, 32'h00400000);
    rd_cp0("cause_reset", A_CAUSE, 32'h0);
    rd_cp0("unmapped_read", 8'h08, 32'h0);

    // MTC0 EXL/EPC, then ERET redirect and kill of the following instruction
    mtc0(A_STATUS, 32'hFFFF_FFFE & 32'h0000_0002);
    step();
    chk("mtc0_no_rf_we", 32'(rf_we), 32'd0);
    rd_cp0("status_exl_set", A_STATUS, 32'h00400002);
    mtc0(A_EPC, 32'hBFC01000);
    step();
    eret_i();
    step();
    chk("eret_flush", 32'(ws_flush), 32'd1);
    chk("eret_flush_pc", ws_flush_pc, 32'hBFC01000);
    alu(32'hBFC00070, 5'd7, 32'h77);
    step();
    chk("killed_rf_we", 32'(rf_we), 32'd0);
    chk("killed_ws_dest", 32'(ws_dest), 32'd0);
    rd_cp0("status_after_eret", A_STATUS, 32'h00400000);

    // AdEL in a delay slot
    exc_i(32'hBFC00104, 5'd4, 1'b1, 32'h3);
    ms_gr_we = 1'b1; ms_dest = 5'd9;
    step();
    chk("adel_flush", 32'(ws_flush), 32'd1);
    chk("adel_flush_pc", ws_flush_pc, 32'hBFC00380);
    chk("adel_rf_we", 32'(rf_we), 32'd0);
    clr();
    step();
    rd_cp0("adel_epc", A_EPC, 32'hBFC00100);
    rd_cp0("adel_badvaddr", A_BADVADDR, 32'h3);
    rd_cp0("adel_cause", A_CAUSE, 32'h80000010);
    rd_cp0("adel_status", A_STATUS, 32'h00400002);

    // Syscall while EXL=1
    exc_i(32'hBFC00200, 5'd8, 1'b0, 32'hDEAD);
    step();
    chk("sys_flush", 32'(ws_flush), 32'd1);
    clr();
    step();
    rd_cp0("sys_epc_kept", A_EPC, 32'hBFC00100);
    rd_cp0("sys_cause", A_CAUSE, 32'h80000020);
    rd_cp0("sys_badvaddr_kept", A_BADVADDR, 32'h3);
    eret_i();
    step();
    chk("eret2_flush_pc", ws_flush_pc, 32'hBFC00100);
    clr();
    step();

    // Count/Compare timer
    mtc0(A_STATUS, 32'h00008001);
    step();
    clr();
    step();
    chk("timer_not_yet", 32'(int_pending), 32'd0);
    mtc0(A_COUNT, 32'h0);
    step();
    mtc0(A_COMPARE, 32'd10);
    step();
    clr();
    n_hit = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (int_pending === 1'b1 && n_hit < 0) n_hit = n;
    end
    chk("ti_latency", 32'(n_hit), 32'd21);
    chk("ti_int_pending", 32'(int_pending), 32'd1);
    rd_cp0("ti_cause", A_CAUSE, 32'hC0008020);
    mtc0(A_COMPARE, 32'h1000);
    step();
    clr();
    step();
    chk("ti_cleared", 32'(int_pending), 32'd0);
    rd_cp0("ti_cleared_cause", A_CAUSE, 32'h80000020);

    // Hardware interrupt masked by EXL, released by ERET
    ext_int = 6'b000001;
    mtc0(A_STATUS, 32'h00000403);
    step();
    clr();
    step();
    chk("hw_int_exl_masked", 32'(int_pending), 32'd0);
    rd_cp0("hw_int_cause", A_CAUSE, 32'h80000420);
    eret_i();
    step();
    chk("hw_int_at_eret", 32'(int_pending), 32'd0);
    clr();
    step();
    chk("hw_int_after_eret", 32'(int_pending), 32'd1);

    // Exception with MTC0 on the same instruction: MTC0 is dropped
    exc_i(32'hBFC00300, 5'd0, 1'b0, 32'h0);
    ms_mtc0 = 1'b1; ms_cp0_addr = A_EPC; ms_result = 32'h55;
    step();
    chk("exc_mtc0_flush", 32'(ws_flush), 32'd1);
    clr();
    step();
    rd_cp0("exc_mtc0_epc", A_EPC, 32'hBFC00300);
    rd_cp0("exc_mtc0_cause", A_CAUSE, 32'h00000400);

    // AdES while EXL=1: BadVAddr updates, EPC holds
    exc_i(32'hBFC00400, 5'd5, 1'b0, 32'h77);
    step();
    clr();
    step();
    rd_cp0("ades_badvaddr", A_BADVADDR, 32'h77);
    rd_cp0("ades_epc_kept", A_EPC, 32'hBFC00300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
